// File: rtl/alu_share_arbiter.sv
// Purpose : shares one external ALU between the execute stage (port 0) and the
//           address/branch unit (port 1) with round-robin arbitration.
// Latency : accept on edge t; response valid at t+3 (legal op) or t+2 (illegal op).
// Backpressure: a port is only granted when its response register is empty; a
//           held response (rspN_valid && !rspN_ready) blocks that port only.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   reqN_valid/ready/control/operandN  request handshake and payload, N = 0,1
//   rspN_valid/ready/result/overflow/zero/illegal  held response per requester
//   alu_control/operand0/operand1   registered drive into the shared ALU
//   alu_result/overflow/zero        combinational results from the shared ALU
module alu_share_arbiter #(
    parameter int          DATA_WIDTH = 32,
    parameter logic [3:0]  IDLE_CODE  = 4'b1111
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [3:0]            req0_control,
    input  logic [DATA_WIDTH-1:0] req0_operand0,
    input  logic [DATA_WIDTH-1:0] req0_operand1,

    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [3:0]            req1_control,
    input  logic [DATA_WIDTH-1:0] req1_operand0,
    input  logic [DATA_WIDTH-1:0] req1_operand1,

    output logic                  rsp0_valid,
    input  logic                  rsp0_ready,
    output logic [DATA_WIDTH-1:0] rsp0_result,
    output logic                  rsp0_overflow,
    output logic                  rsp0_zero,
    output logic                  rsp0_illegal,

    output logic                  rsp1_valid,
    input  logic                  rsp1_ready,
    output logic [DATA_WIDTH-1:0] rsp1_result,
    output logic                  rsp1_overflow,
    output logic                  rsp1_zero,
    output logic                  rsp1_illegal,

    output logic [3:0]            alu_control,
    output logic [DATA_WIDTH-1:0] alu_operand0,
    output logic [DATA_WIDTH-1:0] alu_operand1,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_overflow,
    input  logic                  alu_zero
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        EXEC  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t     state;
    logic       last_grant;   // port granted most recently
    logic       cur_port;     // port owning the operation in flight
    logic [3:0] op_ctrl;      // opcode latched at acceptance

    logic                  elig0;
    logic                  elig1;
    logic                  grant0;
    logic                  grant1;
    logic                  accept;
    logic                  acc_port;
    logic [3:0]            acc_ctrl;
    logic [DATA_WIDTH-1:0] acc_op0;
    logic [DATA_WIDTH-1:0] acc_op1;

    function automatic logic is_legal(input logic [3:0] code);
        logic ok;
        case (code)
            4'b0000, 4'b0001, 4'b0010, 4'b0011,
            4'b0100, 4'b0110, 4'b0111, 4'b1000,
            4'b1001, 4'b1011, 4'b1100: ok = 1'b1;
            default:                   ok = 1'b0;
        endcase
        return ok;
    endfunction

    // A port with a response still held cannot issue; this keeps at most one
    // operation outstanding per requester.
    always_comb begin
        elig0  = req0_valid && !rsp0_valid;
        elig1  = req1_valid && !rsp1_valid;
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE) begin
            if (elig0 && elig1) begin
                // tie: the port that did not win last time goes first
                grant0 = last_grant;
                grant1 = !last_grant;
            end else begin
                grant0 = elig0;
                grant1 = elig1;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign accept     = grant0 || grant1;
    assign acc_port   = grant1;
    assign acc_ctrl   = grant1 ? req1_control  : req0_control;
    assign acc_op0    = grant1 ? req1_operand0 : req0_operand0;
    assign acc_op1    = grant1 ? req1_operand1 : req0_operand1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            last_grant    <= 1'b1;
            cur_port      <= 1'b0;
            op_ctrl       <= IDLE_CODE;
            alu_control   <= IDLE_CODE;
            alu_operand0  <= '0;
            alu_operand1  <= '0;
            rsp0_valid    <= 1'b0;
            rsp0_result   <= '0;
            rsp0_overflow <= 1'b0;
            rsp0_zero     <= 1'b0;
            rsp0_illegal  <= 1'b0;
            rsp1_valid    <= 1'b0;
            rsp1_result   <= '0;
            rsp1_overflow <= 1'b0;
            rsp1_zero     <= 1'b0;
            rsp1_illegal  <= 1'b0;
        end else begin
            // Consumption; payload is left as is once valid drops.
            if (rsp0_valid && rsp0_ready) begin
                rsp0_valid <= 1'b0;
            end
            if (rsp1_valid && rsp1_ready) begin
                rsp1_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    alu_control <= IDLE_CODE;
                    if (accept) begin
                        cur_port   <= acc_port;
                        op_ctrl    <= acc_ctrl;
                        last_grant <= acc_port;
                        if (is_legal(acc_ctrl)) begin
                            // operands reach the ALU one cycle before the opcode
                            alu_operand0 <= acc_op0;
                            alu_operand1 <= acc_op1;
                            state        <= SETUP;
                        end else begin
                            state <= DONE;
                        end
                    end
                end

                SETUP: begin
                    alu_control <= op_ctrl;
                    state       <= EXEC;
                end

                EXEC: begin
                    alu_control <= IDLE_CODE;
                    if (cur_port == 1'b0) begin
                        rsp0_valid    <= 1'b1;
                        rsp0_result   <= alu_result;
                        rsp0_overflow <= alu_overflow;
                        rsp0_zero     <= alu_zero;
                        rsp0_illegal  <= 1'b0;
                    end else begin
                        rsp1_valid    <= 1'b1;
                        rsp1_result   <= alu_result;
                        rsp1_overflow <= alu_overflow;
                        rsp1_zero     <= alu_zero;
                        rsp1_illegal  <= 1'b0;
                    end
                    state <= IDLE;
                end

                DONE: begin
                    // unsupported opcode: answer without touching the ALU
                    alu_control <= IDLE_CODE;
                    if (cur_port == 1'b0) begin
                        rsp0_valid    <= 1'b1;
                        rsp0_result   <= '0;
                        rsp0_overflow <= 1'b0;
                        rsp0_zero     <= 1'b0;
                        rsp0_illegal  <= 1'b1;
                    end else begin
                        rsp1_valid    <= 1'b1;
                        rsp1_result   <= '0;
                        rsp1_overflow <= 1'b0;
                        rsp1_zero     <= 1'b0;
                        rsp1_illegal  <= 1'b1;
                    end
                    state <= IDLE;
                end

                default: begin
                    alu_control <= IDLE_CODE;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Purpose : directed bench for alu_share_arbiter with a schedule-based model.
// Latency : n/a (bench).
// Backpressure: response ready is driven per directed test.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [3:0]  req0_control = 4'h0, req1_control = 4'h0;
    logic [31:0] req0_operand0 = '0, req0_operand1 = '0;
    logic [31:0] req1_operand0 = '0, req1_operand1 = '0;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic [31:0] rsp0_result, rsp1_result;
    logic        rsp0_overflow, rsp1_overflow, rsp0_zero, rsp1_zero;
    logic        rsp0_illegal, rsp1_illegal;
    logic [3:0]  alu_control;
    logic [31:0] alu_operand0, alu_operand1, alu_result;
    logic        alu_overflow, alu_zero;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.DATA_WIDTH(32), .IDLE_CODE(4'b1111)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_control(req0_control),
        .req0_operand0(req0_operand0), .req0_operand1(req0_operand1),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_control(req1_control),
        .req1_operand0(req1_operand0), .req1_operand1(req1_operand1),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
        .rsp0_overflow(rsp0_overflow), .rsp0_zero(rsp0_zero), .rsp0_illegal(rsp0_illegal),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
        .rsp1_overflow(rsp1_overflow), .rsp1_zero(rsp1_zero), .rsp1_illegal(rsp1_illegal),
        .alu_control(alu_control), .alu_operand0(alu_operand0), .alu_operand1(alu_operand1),
        .alu_result(alu_result), .alu_overflow(alu_overflow), .alu_zero(alu_zero)
    );

    // Bench ALU: returns {overflow, result}; unknown codes give a poison value.
    function automatic logic [32:0] alu_f(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        v;
        r = 32'hDEADBEEF;
        v = 1'b0;
        case (c)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd2:  r = a + b;
            4'd3:  r = a ^ b;
            4'd4:  r = ~(a | b);
            4'd6:  r = a - b;
            4'd7:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd8:  r = a << b[4:0];
            4'd9:  r = a >> b[4:0];
            4'd11: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
            4'd12: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
            default: v = 1'b1;
        endcase
        return {v, r};
    endfunction

    always_comb begin
        {alu_overflow, alu_result} = alu_f(alu_control, alu_operand0, alu_operand1);
        alu_zero = (alu_result == 32'd0);
    end

    logic [3:0] legal_list [11] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7, 4'd8, 4'd9, 4'd11, 4'd12};

    function automatic logic legal_tb(input logic [3:0] c);
        foreach (legal_list[i]) if (legal_list[i] == c) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- model: per-cycle schedules ----------------
    int          cyc = 0;
    logic        armed = 1'b0;
    int          free_at = 0;
    int          last = 1;
    logic [3:0]  ctrl_sched [int];
    logic [63:0] op_sched   [int];
    logic [31:0] m_op0 = '0, m_op1 = '0;
    logic        mv [2];
    logic [31:0] mres [2];
    logic        movf [2], mzero [2], mill [2];
    logic        pv [2];
    int          pat [2];
    logic [31:0] pres [2];
    logic        povf [2], pzero [2], pill [2];
    logic [3:0]  prev_ctrl = 4'hF;

    always @(negedge clk) begin
        int          g;
        logic [3:0]  ec;
        logic        rv [2];
        logic [3:0]  rc [2];
        logic [31:0] ra [2], rb [2];
        logic [32:0] f;
        cyc++;
        rv[0] = req0_valid; rc[0] = req0_control; ra[0] = req0_operand0; rb[0] = req0_operand1;
        rv[1] = req1_valid; rc[1] = req1_control; ra[1] = req1_operand0; rb[1] = req1_operand1;
        g = -1;
        if (armed) begin
            for (int p = 0; p < 2; p++) begin
                if (pv[p] && pat[p] == cyc) begin
                    pv[p] = 1'b0; mv[p] = 1'b1;
                    mres[p] = pres[p]; movf[p] = povf[p]; mzero[p] = pzero[p]; mill[p] = pill[p];
                end
            end
            if (op_sched.exists(cyc)) {m_op0, m_op1} = op_sched[cyc];
            ec = ctrl_sched.exists(cyc) ? ctrl_sched[cyc] : 4'hF;
            chk("alu_control", alu_control, ec);
            chk("alu_operand0", alu_operand0, m_op0);
            chk("alu_operand1", alu_operand1, m_op1);
            if (legal_tb(alu_control)) chk("ctrl_repeat", alu_control == prev_ctrl, 0);
            chk("rsp0_valid", rsp0_valid, mv[0]);
            chk("rsp1_valid", rsp1_valid, mv[1]);
            if (mv[0]) begin
                chk("rsp0_result", rsp0_result, mres[0]);
                chk("rsp0_flags", {rsp0_overflow, rsp0_zero, rsp0_illegal}, {movf[0], mzero[0], mill[0]});
            end
            if (mv[1]) begin
                chk("rsp1_result", rsp1_result, mres[1]);
                chk("rsp1_flags", {rsp1_overflow, rsp1_zero, rsp1_illegal}, {movf[1], mzero[1], mill[1]});
            end
            if (rst_n) begin
                if (cyc >= free_at) begin
                    if (rv[0] && !mv[0] && rv[1] && !mv[1]) g = (last == 0) ? 1 : 0;
                    else if (rv[0] && !mv[0]) g = 0;
                    else if (rv[1] && !mv[1]) g = 1;
                end
                chk("req0_ready", req0_ready, g == 0);
                chk("req1_ready", req1_ready, g == 1);
            end
        end
        prev_ctrl = alu_control;
        if (!rst_n) begin
            armed = 1'b1;
            ctrl_sched.delete();
            op_sched.delete();
            op_sched[cyc+1] = 64'd0;
            for (int p = 0; p < 2; p++) begin mv[p] = 1'b0; pv[p] = 1'b0; end
            last = 1;
            free_at = cyc + 1;
        end else if (armed) begin
            if (g >= 0) begin
                last = g;
                pv[g] = 1'b1;
                if (legal_tb(rc[g])) begin
                    f = alu_f(rc[g], ra[g], rb[g]);
                    pat[g] = cyc + 3; pres[g] = f[31:0]; povf[g] = f[32];
                    pzero[g] = (f[31:0] == 32'd0); pill[g] = 1'b0;
                    op_sched[cyc+1] = {ra[g], rb[g]};
                    ctrl_sched[cyc+2] = rc[g];
                    free_at = cyc + 3;
                end else begin
                    pat[g] = cyc + 2; pres[g] = '0; povf[g] = 1'b0; pzero[g] = 1'b0; pill[g] = 1'b1;
                    free_at = cyc + 2;
                end
            end
            if (mv[0] && rsp0_ready) mv[0] = 1'b0;
            if (mv[1] && rsp1_ready) mv[1] = 1'b0;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic set_req(input int p, input logic v, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        if (p == 0) begin req0_valid = v; req0_control = c; req0_operand0 = a; req0_operand1 = b; end
        else        begin req1_valid = v; req1_control = c; req1_operand0 = a; req1_operand1 = b; end
    endtask

    // Called just after a rising edge; returns at the negedge where the response shows.
    task automatic issue(input int p, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [3:0] c1, output logic [3:0] c2);
        logic ok;
        lat = -1; c1 = 4'h0; c2 = 4'h0; ok = 1'b0;
        set_req(p, 1'b1, c, a, b);
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if ((p == 0) ? req0_ready : req1_ready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL accept_timeout port %0d: got no ready expected ready", p);
            set_req(p, 1'b0, c, a, b);
            return;
        end
        @(posedge clk); #1;
        set_req(p, 1'b0, c, a, b);
        for (int k = 1; k < 20; k++) begin
            @(negedge clk);
            if (k == 1) c1 = alu_control;
            if (k == 2) c2 = alu_control;
            if ((p == 0) ? rsp0_valid : rsp1_valid) begin lat = k; break; end
        end
        if (lat < 0) begin
            total++; bad++;
            $display("FAIL rsp_timeout port %0d: got no rsp expected rsp", p);
        end
    endtask

    task automatic ack(input int p);
        @(posedge clk); #1;
        if (p == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
        @(posedge clk); #1;
        if (p == 0) rsp0_ready = 1'b0; else rsp1_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1; rst_n = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1; rst_n = 1'b1;
    endtask

    initial begin
        int         lat;
        logic [3:0] c1, c2;
        int         grants [$];
        int         r0hits;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_state", {rsp0_valid, rsp1_valid, alu_control, rsp0_result, rsp1_illegal},
            {1'b0, 1'b0, 4'hF, 32'd0, 1'b0});
        chk("reset_operands", {alu_operand0, alu_operand1}, 64'd0);

        // single add on port 0
        @(posedge clk); #1;
        issue(0, 4'b0010, 32'h5, 32'h3, lat, c1, c2);
        chk("add_latency", lat, 3);
        chk("add_ctrl_setup", c1, 4'hF);
        chk("add_ctrl_exec", c2, 4'h2);
        chk("add_rsp", {rsp0_result, rsp0_zero, rsp0_overflow, rsp0_illegal}, {32'h8, 3'b000});
        repeat (4) @(negedge clk);
        chk("add_held", {rsp0_valid, rsp0_result}, {1'b1, 32'h8});
        ack(0);

        // both ports continuously with responses always consumed
        do_reset();
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        set_req(0, 1'b1, 4'b0010, 32'd1, 32'd2);
        set_req(1, 1'b1, 4'b0110, 32'd10, 32'd3);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req0_ready && req0_valid) grants.push_back(0);
            if (req1_ready && req1_valid) grants.push_back(1);
        end
        @(posedge clk); #1;
        set_req(0, 1'b0, 4'h0, 0, 0); set_req(1, 1'b0, 4'h0, 0, 0);
        chk("rr_count", grants.size() >= 6, 1);
        if (grants.size() >= 4)
            chk("rr_order", {grants[0][1:0], grants[1][1:0], grants[2][1:0], grants[3][1:0]}, 8'b00_01_00_01);
        repeat (5) @(posedge clk);
        #1 rsp0_ready = 1'b0; rsp1_ready = 1'b0;

        // signed overflow and zero on port 1
        issue(1, 4'b1011, 32'h7FFFFFFF, 32'h1, lat, c1, c2);
        chk("sadd_rsp", {rsp1_result, rsp1_overflow, rsp1_zero}, {32'h80000000, 2'b10});
        ack(1);
        #1;
        issue(1, 4'b1100, 32'h5, 32'h5, lat, c1, c2);
        chk("ssub_rsp", {rsp1_result, rsp1_overflow, rsp1_zero}, {32'h0, 2'b01});
        ack(1);

        // illegal opcode
        #1;
        issue(0, 4'b0101, 32'h1234, 32'h1, lat, c1, c2);
        chk("illegal_latency", lat, 2);
        chk("illegal_ctrl", {c1, c2}, 8'hFF);
        chk("illegal_rsp", {rsp0_illegal, rsp0_result, rsp0_valid}, {1'b1, 32'h0, 1'b1});
        ack(0);

        // held rsp0 blocks port 0 only
        #1;
        issue(0, 4'b0000, 32'hF0F0, 32'hFF00, lat, c1, c2);
        @(posedge clk); #1;
        set_req(0, 1'b1, 4'b0000, 32'hF0F0, 32'hFF00);
        issue(1, 4'b0001, 32'h0F, 32'hF0, lat, c1, c2);
        chk("served_p1", {rsp1_result, lat[3:0]}, {32'hFF, 4'd3});
        r0hits = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (req0_ready) r0hits++;
        end
        chk("p0_not_regranted", r0hits, 0);
        chk("rsp0_held", {rsp0_valid, rsp0_result, rsp0_illegal}, {1'b1, 32'hF000, 1'b0});
        @(posedge clk); #1;
        req0_valid = 1'b0; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        @(posedge clk); #1;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;

        // reset asserted during EXEC
        @(posedge clk); #1;
        set_req(0, 1'b1, 4'b0010, 32'h11, 32'h22);
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (req0_ready) break;
        end
        @(posedge clk); #1; req0_valid = 1'b0;
        @(posedge clk); #1; rst_n = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        chk("rst_exec", {rsp0_valid, rsp1_valid, alu_control}, {2'b00, 4'hF});
        repeat (3) @(negedge clk);
        chk("rst_exec_norsp", rsp0_valid, 1'b0);
        @(posedge clk); #1;
        issue(0, 4'b0110, 32'h20, 32'h8, lat, c1, c2);
        chk("after_rst", {rsp0_result, lat[3:0]}, {32'h18, 4'd3});
        ack(0);
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one 32-bit arithmetic_logic_unit instance between two requesters: port 0 is the execute stage, port 1 is the address/branch unit.
- Arbitrates between them round-robin and sequences each operation through the ALU.
- Captures result/overflow/zero into a per-requester response register, held until that requester acknowledges it.
- Sits between the pipeline control and the ALU; the ALU instance itself stays outside this block.

Parameters:
- DATA_WIDTH, 32, operand/result width; must equal ALU width.
- IDLE_CODE, 4'b1111, ALU control value driven whenever no operation is issued; not a legal opcode.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- reqN_valid  input  1  request N present (N = 0,1)
- reqN_ready  output  1  request N accepted this cycle when valid&&ready
- reqN_control  input  4  ALU opcode for request N
- reqN_operand0  input  DATA_WIDTH  first operand for request N
- reqN_operand1  input  DATA_WIDTH  second operand for request N
- rspN_valid  output  1  response N held
- rspN_ready  input  1  requester N consumes response
- rspN_result  output  DATA_WIDTH  captured result for N
- rspN_overflow  output  1  captured overflow flag for N
- rspN_zero  output  1  captured zero flag for N
- rspN_illegal  output  1  request carried an unsupported opcode
- alu_control  output  4  to ALU control
- alu_operand0  output  DATA_WIDTH  to ALU operand0
- alu_operand1  output  DATA_WIDTH  to ALU operand1
- alu_result  input  DATA_WIDTH  from ALU
- alu_overflow  input  1  from ALU
- alu_zero  input  1  from ALU

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-low, rst_n. All state is updated only on the rising edge of clk.
- Reset: on any edge with rst_n=0:
  - state=IDLE, last_grant=1 (so port 0 wins the first tie);
  - rspN_valid/result/overflow/zero/illegal=0;
  - alu_control=IDLE_CODE, alu_operand0/1=0.
  - An in-flight operation is discarded and produces no response.
- Legal opcodes: 0000, 0001, 0010, 0011, 0100, 0110, 0111, 1000, 1001, 1011, 1100. All other codes are illegal.
- Eligibility: port N is eligible when reqN_valid=1 and rspN_valid=0. A port never has more than one operation outstanding.
- IDLE:
  - If exactly one port is eligible, grant it.
  - If both are eligible, grant the port other than last_grant.
  - reqN_ready=1 only for the granted port, only in IDLE; at most one ready is high per cycle.
  - On acceptance: latch control, operands and the port id; set last_grant to that port.
  - Legal opcode -> SETUP. Illegal opcode -> DONE with illegal=1 (the ALU is not used).
- SETUP (1 cycle): alu_operand0/1 = latched operands; alu_control = IDLE_CODE.
- EXEC (1 cycle): alu_control = latched opcode; operands held unchanged. This guarantees a control transition with operands already stable for every issued op. At the end of the EXEC edge, capture alu_result/overflow/zero into the granted port's response register, set rspN_valid=1 and rspN_illegal=0, then go to IDLE.
- DONE (illegal path, 1 cycle): rspN_valid=1, result=0, overflow=0, zero=0, illegal=1; then go to IDLE.
- Outside EXEC: alu_control=IDLE_CODE. Operands keep their last value.
- Latency: acceptance on edge t, response visible (rspN_valid=1) on cycle t+3 for legal ops and t+2 for illegal ops. Peak throughput is one op per 3 cycles.
- Response hold: rspN_* are stable while rspN_valid=1 and rspN_ready=0. rspN_valid clears on the edge where rspN_ready=1. Port N becomes eligible again in the following cycle, not the same one.
- Responses are independent: port 1 may be served while rsp0 is still held.
- rspN_ready while rspN_valid=0 is ignored.
- Requester rule: reqN_valid and its operands are held stable until accepted. Dropping valid before acceptance is allowed and simply withdraws the request.

Test Plan:
- Reset then req0 add 0x00000005+0x00000003 alone -> req0_ready at t, alu_control=1111 at t+1 then 0010 at t+2, rsp0_valid at t+3 with result=0x00000008, zero=0, overflow=0; held until rsp0_ready.
- req0 and req1 valid together continuously, rsp_ready tied 1 -> grants alternate 0,1,0,1; first grant is port 0; alu_control is never the same legal opcode on two consecutive cycles.
- req1 signed add 0x7FFFFFFF+0x00000001 (1011) -> rsp1_result=0x80000000, rsp1_overflow=1; signed sub 0x00000005-0x00000005 (1100) -> result 0, zero=1.
- req0 control=0101 -> accepted, rsp0_valid at t+2, illegal=1, result=0; alu_control stays 1111 throughout.
- rsp0_ready held 0 with req0 still valid while req1 requests -> port 0 is not regranted, port 1 is served; rsp0 values are unchanged over 10 cycles.
- rst_n=0 asserted in EXEC -> next cycle state IDLE, no rsp_valid, alu_control=1111; the next request completes normally.
